// File: rtl/a3_sq_decoder_if.sv
// rtl/a3_sq_decoder_if.sv - pulse inputs and decoded outputs of the sequence-register decoder
interface a3_sq_decoder_if;
    logic [5:0]  wl;
    logic        nisq;
    logic        extpls;
    logic        inhpls;
    logic        relpls;
    logic        krpt;
    logic        rsm;
    logic        gojam;

    logic [5:0]  sq;
    logic        sqext;
    logic        futext;
    logic [3:0]  qc;
    logic [27:0] instr;
    logic        inhint;
    logic        iip;
    logic        rpt_ok;

    modport master (
        output wl, nisq, extpls, inhpls, relpls, krpt, rsm, gojam,
        input  sq, sqext, futext, qc, instr, inhint, iip, rpt_ok
    );

    modport slave (
        input  wl, nisq, extpls, inhpls, relpls, krpt, rsm, gojam,
        output sq, sqext, futext, qc, instr, inhint, iip, rpt_ok
    );
endinterface

// File: rtl/a3_sq_decoder.sv
// rtl/a3_sq_decoder.sv - sequence register, extend flag and one-hot instruction decode
// Interrupt inhibit / in-progress flags are built only when A3_RUPT_EN is defined.
module a3_sq_decoder (
    input  logic              CLOCK,
    input  logic              rst,
    a3_sq_decoder_if.slave    bus
);
    localparam logic [4:0] I_TC   = 5'd0;
    localparam logic [4:0] I_CCS  = 5'd1;
    localparam logic [4:0] I_TCF  = 5'd2;
    localparam logic [4:0] I_DAS  = 5'd3;
    localparam logic [4:0] I_LXCH = 5'd4;
    localparam logic [4:0] I_INCR = 5'd5;
    localparam logic [4:0] I_ADS  = 5'd6;
    localparam logic [4:0] I_CA   = 5'd7;
    localparam logic [4:0] I_CS   = 5'd8;
    localparam logic [4:0] I_NDX  = 5'd9;
    localparam logic [4:0] I_DXCH = 5'd10;
    localparam logic [4:0] I_TS   = 5'd11;
    localparam logic [4:0] I_XCH  = 5'd12;
    localparam logic [4:0] I_AD   = 5'd13;
    localparam logic [4:0] I_MASK = 5'd14;
    localparam logic [4:0] I_IO   = 5'd15;
    localparam logic [4:0] I_DV   = 5'd16;
    localparam logic [4:0] I_BZF  = 5'd17;
    localparam logic [4:0] I_MSU  = 5'd18;
    localparam logic [4:0] I_QXCH = 5'd19;
    localparam logic [4:0] I_AUG  = 5'd20;
    localparam logic [4:0] I_DIM  = 5'd21;
    localparam logic [4:0] I_DCA  = 5'd22;
    localparam logic [4:0] I_DCS  = 5'd23;
    localparam logic [4:0] I_NDXX = 5'd24;
    localparam logic [4:0] I_SU   = 5'd25;
    localparam logic [4:0] I_BZMF = 5'd26;
    localparam logic [4:0] I_MP   = 5'd27;

    logic [5:0] sq_q, sq_d;
    logic       sqext_q, sqext_d;
    logic       futext_q, futext_d;
    logic       inhint_w, iip_w;

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            sq_q     <= '0;
            sqext_q  <= 1'b0;
            futext_q <= 1'b0;
        end else begin
            sq_q     <= sq_d;
            sqext_q  <= sqext_d;
            futext_q <= futext_d;
        end
    end

    // extpls dominates the nisq clear so EXTEND landing on a load still arms the next one.
    always_comb begin
        sq_d     = sq_q;
        sqext_d  = sqext_q;
        futext_d = futext_q;
        if (bus.gojam) begin
            sq_d     = '0;
            sqext_d  = 1'b0;
            futext_d = 1'b0;
        end else begin
            if (bus.nisq) begin
                sq_d     = bus.wl;
                sqext_d  = futext_q;
                futext_d = 1'b0;
            end
            if (bus.extpls) begin
                futext_d = 1'b1;
            end
        end
    end

`ifdef A3_RUPT_EN
    logic inhint_q, inhint_d;
    logic iip_q, iip_d;

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            inhint_q <= 1'b0;
            iip_q    <= 1'b0;
        end else begin
            inhint_q <= inhint_d;
            iip_q    <= iip_d;
        end
    end

    always_comb begin
        inhint_d = inhint_q;
        iip_d    = iip_q;
        if (bus.gojam) begin
            inhint_d = 1'b0;
            iip_d    = 1'b0;
        end else begin
            if (bus.inhpls)      inhint_d = 1'b1;
            else if (bus.relpls) inhint_d = 1'b0;
            if (bus.krpt)        iip_d    = 1'b1;
            else if (bus.rsm)    iip_d    = 1'b0;
        end
    end

    assign inhint_w = inhint_q;
    assign iip_w    = iip_q;
`else
    logic unused_rupt;
    assign unused_rupt = ^{bus.inhpls, bus.relpls, bus.krpt, bus.rsm};
    assign inhint_w    = 1'b0;
    assign iip_w       = 1'b0;
`endif

    logic [2:0] oc;
    logic [1:0] qq;
    logic [4:0] dec_idx;
    logic [3:0] qc_w;

    assign oc = sq_q[5:3];
    assign qq = sq_q[2:1];

    // sq[0] never reaches the decode; it only distinguishes addresses within a quarter.
    always_comb begin
        dec_idx = I_TC;
        if (!sqext_q) begin
            unique case (oc)
                3'd0: dec_idx = I_TC;
                3'd1: dec_idx = (qq == 2'd0) ? I_CCS : I_TCF;
                3'd2: begin
                    unique case (qq)
                        2'd0: dec_idx = I_DAS;
                        2'd1: dec_idx = I_LXCH;
                        2'd2: dec_idx = I_INCR;
                        2'd3: dec_idx = I_ADS;
                    endcase
                end
                3'd3: dec_idx = I_CA;
                3'd4: dec_idx = I_CS;
                3'd5: begin
                    unique case (qq)
                        2'd0: dec_idx = I_NDX;
                        2'd1: dec_idx = I_DXCH;
                        2'd2: dec_idx = I_TS;
                        2'd3: dec_idx = I_XCH;
                    endcase
                end
                3'd6: dec_idx = I_AD;
                3'd7: dec_idx = I_MASK;
            endcase
        end else begin
            unique case (oc)
                3'd0: dec_idx = I_IO;
                3'd1: dec_idx = (qq == 2'd0) ? I_DV : I_BZF;
                3'd2: begin
                    unique case (qq)
                        2'd0: dec_idx = I_MSU;
                        2'd1: dec_idx = I_QXCH;
                        2'd2: dec_idx = I_AUG;
                        2'd3: dec_idx = I_DIM;
                    endcase
                end
                3'd3: dec_idx = I_DCA;
                3'd4: dec_idx = I_DCS;
                3'd5: dec_idx = I_NDXX;
                3'd6: dec_idx = (qq == 2'd0) ? I_SU : I_BZMF;
                3'd7: dec_idx = I_MP;
            endcase
        end
    end

    always_comb begin
        qc_w     = '0;
        qc_w[qq] = 1'b1;
    end

    assign bus.sq     = sq_q;
    assign bus.sqext  = sqext_q;
    assign bus.futext = futext_q;
    assign bus.qc     = qc_w;
    assign bus.instr  = 28'd1 << dec_idx;
    assign bus.inhint = inhint_w;
    assign bus.iip    = iip_w;
    assign bus.rpt_ok = ~inhint_w & ~iip_w & ~futext_q & ~sqext_q;
endmodule

// File: tb/tb_a3_sq_decoder.sv
// tb/tb_a3_sq_decoder.sv - scoreboard bench for a3_sq_decoder
module tb_a3_sq_decoder;
    logic CLOCK;
    logic rst;
    a3_sq_decoder_if bus ();

    a3_sq_decoder dut (.CLOCK(CLOCK), .rst(rst), .bus(bus));

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [5:0]  sq;
        logic        sqext;
        logic        futext;
        logic [3:0]  qc;
        logic [27:0] instr;
        logic        inhint;
        logic        iip;
        logic        rpt_ok;
    } exp_t;

    // Instruction index per {sqext, oc, q}, written out from the opcode tables.
    int dec_tab [64] = '{
        0, 0, 0, 0,      1, 2, 2, 2,      3, 4, 5, 6,      7, 7, 7, 7,
        8, 8, 8, 8,      9, 10, 11, 12,   13, 13, 13, 13,  14, 14, 14, 14,
        15, 15, 15, 15,  16, 17, 17, 17,  18, 19, 20, 21,  22, 22, 22, 22,
        23, 23, 23, 23,  24, 24, 24, 24,  25, 26, 26, 26,  27, 27, 27, 27
    };

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   edges_taken = 0;
    int   edges_checked = 0;

    logic [5:0] m_sq;
    logic       m_sqext, m_futext, m_inhint, m_iip;

    function automatic exp_t model_out();
        exp_t e;
        int   idx;
        idx      = dec_tab[{m_sqext, m_sq[5:1]}];
        e.sq     = m_sq;
        e.sqext  = m_sqext;
        e.futext = m_futext;
        e.qc     = 4'b0001 << m_sq[2:1];
        e.instr  = 28'd1 << idx;
        e.inhint = m_inhint;
        e.iip    = m_iip;
        e.rpt_ok = !m_inhint && !m_iip && !m_futext && !m_sqext;
        return e;
    endfunction

    task automatic step(input logic [5:0] w, input logic n, input logic e,
                        input logic ih, input logic rl, input logic kr,
                        input logic rs, input logic gj);
        logic old_fut;
        bus.wl = w; bus.nisq = n; bus.extpls = e; bus.inhpls = ih;
        bus.relpls = rl; bus.krpt = kr; bus.rsm = rs; bus.gojam = gj;
        old_fut = m_futext;
        if (gj) begin
            m_sq = '0; m_sqext = 0; m_futext = 0; m_inhint = 0; m_iip = 0;
        end else begin
            if (n) begin
                m_sq = w; m_sqext = old_fut; m_futext = 0;
            end
            if (e) m_futext = 1;
`ifdef A3_RUPT_EN
            if (ih) m_inhint = 1; else if (rl) m_inhint = 0;
            if (kr) m_iip = 1;    else if (rs) m_iip = 0;
`endif
        end
        exp_q.push_back(model_out());
        @(posedge CLOCK);
        edges_taken++;
        #1;
        bus.wl = '0; bus.nisq = 0; bus.extpls = 0; bus.inhpls = 0;
        bus.relpls = 0; bus.krpt = 0; bus.rsm = 0; bus.gojam = 0;
    endtask

    // Scoreboard: one popped expectation per clock edge that carried stimulus.
    always @(negedge CLOCK) begin
        exp_t e;
        if (edges_checked < edges_taken) begin
            edges_checked++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.sq !== e.sq) begin errors++; $display("FAIL sq: got %b want %b at %0t", bus.sq, e.sq, $time); end
                checks++;
                if (bus.sqext !== e.sqext) begin errors++; $display("FAIL sqext: got %b want %b at %0t", bus.sqext, e.sqext, $time); end
                checks++;
                if (bus.futext !== e.futext) begin errors++; $display("FAIL futext: got %b want %b at %0t", bus.futext, e.futext, $time); end
                checks++;
                if (bus.qc !== e.qc) begin errors++; $display("FAIL qc: got %b want %b at %0t", bus.qc, e.qc, $time); end
                checks++;
                if (bus.instr !== e.instr) begin errors++; $display("FAIL instr: got %h want %h at %0t", bus.instr, e.instr, $time); end
                checks++;
                if (bus.inhint !== e.inhint) begin errors++; $display("FAIL inhint: got %b want %b at %0t", bus.inhint, e.inhint, $time); end
                checks++;
                if (bus.iip !== e.iip) begin errors++; $display("FAIL iip: got %b want %b at %0t", bus.iip, e.iip, $time); end
                checks++;
                if (bus.rpt_ok !== e.rpt_ok) begin errors++; $display("FAIL rpt_ok: got %b want %b at %0t", bus.rpt_ok, e.rpt_ok, $time); end
                checks++;
                if (!$onehot(bus.instr)) begin errors++; $display("FAIL instr_onehot: got %h want one bit set", bus.instr); end
            end
        end
    end

    task automatic test_reset();
        rst = 0;
        bus.wl = '0; bus.nisq = 0; bus.extpls = 0; bus.inhpls = 0;
        bus.relpls = 0; bus.krpt = 0; bus.rsm = 0; bus.gojam = 0;
        m_sq = '0; m_sqext = 0; m_futext = 0; m_inhint = 0; m_iip = 0;
        #3;
        checks++;
        if (bus.sq !== 6'b0 || bus.sqext !== 1'b0 || bus.futext !== 1'b0) begin
            errors++; $display("FAIL reset_state: got sq=%b sqext=%b futext=%b want 0/0/0", bus.sq, bus.sqext, bus.futext);
        end
        checks++;
        if (bus.qc !== 4'b0001 || bus.instr !== 28'h0000001) begin
            errors++; $display("FAIL reset_decode: got qc=%b instr=%h want 0001/0000001", bus.qc, bus.instr);
        end
        checks++;
        if (bus.inhint !== 1'b0 || bus.iip !== 1'b0 || bus.rpt_ok !== 1'b1) begin
            errors++; $display("FAIL reset_rupt: got inhint=%b iip=%b rpt_ok=%b want 0/0/1", bus.inhint, bus.iip, bus.rpt_ok);
        end
        @(posedge CLOCK); #1;
        rst = 1;
    endtask

    task automatic test_load_das();
        step(6'b010000, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.sq !== 6'b010000 || bus.instr !== 28'h0000008 || bus.qc !== 4'b0001) begin
            errors++; $display("FAIL load_das: got sq=%b instr=%h qc=%b want 010000/0000008/0001", bus.sq, bus.instr, bus.qc);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) step(6'($urandom), 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.sq !== 6'b001010 || bus.futext !== 1'b1 || bus.sqext !== 1'b0) begin
            errors++; $display("FAIL hold: got sq=%b futext=%b sqext=%b want 001010/1/0", bus.sq, bus.futext, bus.sqext);
        end
    endtask

    task automatic test_rupt();
`ifdef A3_RUPT_EN
        step(6'b0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.inhint !== 1'b1) begin errors++; $display("FAIL inh_wins: got %b want 1", bus.inhint); end
        step(6'b0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.inhint !== 1'b0) begin errors++; $display("FAIL relint: got %b want 0", bus.inhint); end
        step(6'b0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (bus.iip !== 1'b1 || bus.rpt_ok !== 1'b0) begin errors++; $display("FAIL krpt: got iip=%b rpt_ok=%b want 1/0", bus.iip, bus.rpt_ok); end
        step(6'b0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (bus.iip !== 1'b0 || bus.rpt_ok !== 1'b1) begin errors++; $display("FAIL rsm: got iip=%b rpt_ok=%b want 0/1", bus.iip, bus.rpt_ok); end
        step(6'b0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (bus.iip !== 1'b1) begin errors++; $display("FAIL krpt_wins: got %b want 1", bus.iip); end
        step(6'b0, 0, 0, 0, 0, 0, 1, 0);
`else
        step(6'b0, 0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (bus.inhint !== 1'b0 || bus.iip !== 1'b0 || bus.rpt_ok !== 1'b1) begin
            errors++; $display("FAIL rupt_disabled: got inhint=%b iip=%b rpt_ok=%b want 0/0/1", bus.inhint, bus.iip, bus.rpt_ok);
        end
`endif
    endtask

    task automatic test_extend_mp();
        step(6'b0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.futext !== 1'b1 || bus.rpt_ok !== 1'b0) begin errors++; $display("FAIL extpls: got futext=%b rpt_ok=%b want 1/0", bus.futext, bus.rpt_ok); end
        step(6'b111000, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.sqext !== 1'b1 || bus.futext !== 1'b0 || bus.instr !== 28'h8000000 || bus.rpt_ok !== 1'b0) begin
            errors++; $display("FAIL extend_mp: got sqext=%b futext=%b instr=%h rpt_ok=%b want 1/0/8000000/0", bus.sqext, bus.futext, bus.instr, bus.rpt_ok);
        end
    endtask

    task automatic test_coincident();
        step(6'b001010, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.sqext !== 1'b0 || bus.futext !== 1'b1 || bus.instr !== 28'h0000004) begin
            errors++; $display("FAIL coincident: got sqext=%b futext=%b instr=%h want 0/1/0000004", bus.sqext, bus.futext, bus.instr);
        end
    endtask

    task automatic test_gojam();
        step(6'b111111, 0, 0, 1, 0, 1, 0, 0);
        step(6'b110110, 1, 1, 1, 0, 1, 0, 1);
        checks++;
        if (bus.sq !== 6'b0 || bus.sqext !== 1'b0 || bus.futext !== 1'b0 || bus.inhint !== 1'b0 ||
            bus.iip !== 1'b0 || bus.instr !== 28'h0000001) begin
            errors++; $display("FAIL gojam: got sq=%b sqext=%b futext=%b inhint=%b iip=%b instr=%h want all clear, instr 0000001",
                               bus.sq, bus.sqext, bus.futext, bus.inhint, bus.iip, bus.instr);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 64; i++) begin
            logic [5:0] w;
            w = {i[4:0], 1'($urandom)};
            if (i[5]) step(6'b0, 0, 1, 0, 0, 0, 0, 0);
            step(w, 1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (bus.sqext !== i[5] || bus.sq !== w) begin
                errors++; $display("FAIL sweep_load %0d: got sqext=%b sq=%b want %b/%b", i, bus.sqext, bus.sq, i[5], w);
            end
        end
    endtask

    task automatic test_async_reset();
        step(6'b101110, 1, 1, 1, 0, 0, 0, 0);
        @(negedge CLOCK); #2;
        rst = 0;
        #1;
        checks++;
        if (bus.sq !== 6'b0 || bus.futext !== 1'b0 || bus.instr !== 28'h0000001 || bus.rpt_ok !== 1'b1) begin
            errors++; $display("FAIL async_reset: got sq=%b futext=%b instr=%h rpt_ok=%b want 0/0/0000001/1", bus.sq, bus.futext, bus.instr, bus.rpt_ok);
        end
        m_sq = '0; m_sqext = 0; m_futext = 0; m_inhint = 0; m_iip = 0;
        @(posedge CLOCK); #1;
        rst = 1;
        step(6'b011010, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_das();
        test_rupt();
        test_extend_mp();
        test_coincident();
        test_hold();
        test_gojam();
        test_sweep();
        test_async_reset();
        repeat (2) @(posedge CLOCK);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
